sd_rx_fifo_pack: RTL and testbench

Receive-direction data buffer between the SD data-line deserializer and the host-side bus master.
- The deserializer delivers one 4-bit nibble per strobe, MSB-nibble first, as it samples DAT[3:0].
- The block packs 8 nibbles into a 32-bit word and stores it in a word-wide circular buffer.
- The bus side reads words with first-word-fall-through semantics.
- Single clock domain (SD side and read side share clk).

---
 rtl/sd_rx_fifo_pack.sv | 97 +++++++++
 tb/tb_sd_rx_fifo_pack.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/sd_rx_fifo_pack.sv
// SD receive buffer: packs deserializer nibbles into 32-bit words and queues them for FWFT reads.
// Optional macro SD_RX_FIFO_BSWAP_EN byte-swaps q for little-endian bus masters.
module sd_rx_fifo_pack #(
  parameter int unsigned ADR_SIZE = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [3:0]          d,
  input  logic                wr,
  input  logic                flush,
  output logic [31:0]         q,
  input  logic                rd,
  output logic                full,
  output logic                empty,
  output logic [ADR_SIZE:0]   word_cnt,
  output logic [2:0]          nib_cnt,
  output logic                overrun,
  input  logic                ovr_clr
);

  localparam int unsigned DEPTH = 2 ** ADR_SIZE;
  localparam int unsigned PW    = ADR_SIZE + 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  logic [31:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [31:0]   shreg, shreg_nxt, shifted, push_word, rd_word;
  logic [2:0]    nib_nxt;
  logic          push, pop, accept, ovr_set;

  // Packer: shift in nibbles, emit a word on the 8th nibble or a padded word on flush
  always_comb begin
    shreg_nxt = shreg;
    nib_nxt   = nib_cnt;
    push      = 1'b0;
    push_word = '0;
    shifted   = {shreg[27:0], d};
    if (wr) begin
      shreg_nxt = shifted;
      if (nib_cnt == 3'd7) begin
        push      = 1'b1;
        push_word = shifted;
        nib_nxt   = 3'd0;
      end else if (flush) begin
        push      = 1'b1;
        push_word = shifted << {3'(3'd7 - nib_cnt), 2'b00};
        nib_nxt   = 3'd0;
      end else begin
        nib_nxt   = nib_cnt + 3'd1;
      end
    end else if (flush && (nib_cnt != 3'd0)) begin
      push      = 1'b1;
      push_word = shreg << {3'(4'd8 - {1'b0, nib_cnt}), 2'b00};
      nib_nxt   = 3'd0;
    end
  end

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[ADR_SIZE-1:0] == rd_ptr[ADR_SIZE-1:0]) &&
                    (wr_ptr[ADR_SIZE] != rd_ptr[ADR_SIZE]);
  assign word_cnt = wr_ptr - rd_ptr;

  // A pop in the same cycle frees the slot a full buffer would otherwise refuse
  assign pop     = rd && !empty;
  assign accept  = push && (!full || pop);
  assign ovr_set = push && full && !pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      shreg   <= '0;
      nib_cnt <= 3'd0;
      overrun <= 1'b0;
    end else begin
      shreg   <= shreg_nxt;
      nib_cnt <= nib_nxt;
      if (accept) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)    rd_ptr <= rd_ptr + PTR_ONE;
      if (ovr_set)      overrun <= 1'b1;
      else if (ovr_clr) overrun <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr[ADR_SIZE-1:0]] <= push_word;
  end

  assign rd_word = mem[rd_ptr[ADR_SIZE-1:0]];

`ifdef SD_RX_FIFO_BSWAP_EN
  assign q = {rd_word[7:0], rd_word[15:8], rd_word[23:16], rd_word[31:24]};
`else
  assign q = rd_word;
`endif

endmodule

// File: tb/tb_sd_rx_fifo_pack.sv
// Scoreboard bench for sd_rx_fifo_pack: stimulus queues expected words, a negedge monitor checks pops.
module tb_sd_rx_fifo_pack;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  d = 4'd0;
  logic        wr = 1'b0;
  logic        flush = 1'b0;
  logic        rd = 1'b0;
  logic        ovr_clr = 1'b0;
  logic [31:0] q;
  logic        full, empty, overrun;
  logic [4:0]  word_cnt;
  logic [2:0]  nib_cnt;

  int errors = 0;
  int checks = 0;
  logic [31:0] sb[$];

  sd_rx_fifo_pack #(.ADR_SIZE(4)) dut (
    .clk(clk), .rst(rst), .d(d), .wr(wr), .flush(flush), .q(q), .rd(rd),
    .full(full), .empty(empty), .word_cnt(word_cnt), .nib_cnt(nib_cnt),
    .overrun(overrun), .ovr_clr(ovr_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] map(input logic [31:0] w);
`ifdef SD_RX_FIFO_BSWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  // Monitor: every accepted pop must match the head of the scoreboard
  always @(negedge clk) begin
    if (rst && rd && !empty) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected: got %h required no word", q);
      end else begin
        check("pop_data", q, sb.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic nib(input logic [3:0] v);
    wr = 1'b1; d = v;
    step();
    wr = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input logic rd_last, input logic clr_last);
    for (int i = 0; i < 8; i++) begin
      wr = 1'b1;
      d = w[31-4*i -: 4];
      rd = rd_last && (i == 7);
      ovr_clr = clr_last && (i == 7);
      step();
    end
    wr = 1'b0; rd = 1'b0; ovr_clr = 1'b0;
  endtask

  task automatic drain(input int n);
    rd = 1'b1;
    repeat (n) step();
    rd = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) step();
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_word_cnt", 32'(word_cnt), 32'd0);
    check("rst_nib_cnt", 32'(nib_cnt), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    rst = 1'b1;
    step();

    // First word and one-cycle visibility
    sb.push_back(map(32'h12345678));
    send_word(32'h12345678, 1'b0, 1'b0);
    check("w1_empty", 32'(empty), 32'd0);
    check("w1_word_cnt", 32'(word_cnt), 32'd1);
    check("w1_nib_cnt", 32'(nib_cnt), 32'd0);
    drain(1);
    check("w1_empty_after_rd", 32'(empty), 32'd1);

    // Fill to full, then overflow and overrun handling
    for (int i = 0; i < 16; i++) begin
      sb.push_back(map(32'hA000_0000 + 32'(i)));
      send_word(32'hA000_0000 + 32'(i), 1'b0, 1'b0);
    end
    check("fill_full", 32'(full), 32'd1);
    check("fill_word_cnt", 32'(word_cnt), 32'd16);
    send_word(32'hDEADBEEF, 1'b0, 1'b0);
    check("ovf_overrun", 32'(overrun), 32'd1);
    check("ovf_word_cnt", 32'(word_cnt), 32'd16);
    ovr_clr = 1'b1; step(); ovr_clr = 1'b0;
    check("clr_overrun", 32'(overrun), 32'd0);
    send_word(32'hDEADBEEF, 1'b0, 1'b1);
    check("set_beats_clr", 32'(overrun), 32'd1);
    ovr_clr = 1'b1; step(); ovr_clr = 1'b0;
    check("clr_overrun2", 32'(overrun), 32'd0);

    // Push and pop together while full
    sb.push_back(map(32'hB000_0000));
    send_word(32'hB000_0000, 1'b1, 1'b0);
    check("fullpp_overrun", 32'(overrun), 32'd0);
    check("fullpp_word_cnt", 32'(word_cnt), 32'd16);
    check("fullpp_full", 32'(full), 32'd1);
    for (int k = 0; k < 40; k++) begin
      sb.push_back(map(32'hC000_0000 + 32'(k)));
      send_word(32'hC000_0000 + 32'(k), 1'b1, 1'b0);
    end
    check("wrap_word_cnt", 32'(word_cnt), 32'd16);
    check("wrap_overrun", 32'(overrun), 32'd0);
    drain(16);
    check("wrap_empty", 32'(empty), 32'd1);
    check("wrap_word_cnt0", 32'(word_cnt), 32'd0);

    // Flush variants
    nib(4'hA); nib(4'hB); nib(4'hC);
    check("pre_flush_nib", 32'(nib_cnt), 32'd3);
    sb.push_back(map(32'hABC0_0000));
    flush = 1'b1; step(); flush = 1'b0;
    check("flush_nib", 32'(nib_cnt), 32'd0);
    check("flush_word_cnt", 32'(word_cnt), 32'd1);
    flush = 1'b1; step(); flush = 1'b0;
    check("flush_noop", 32'(word_cnt), 32'd1);
    for (int i = 1; i <= 7; i++) nib(4'(i));
    sb.push_back(map(32'h1234_5675));
    wr = 1'b1; d = 4'h5; flush = 1'b1; step(); wr = 1'b0; flush = 1'b0;
    check("wrflush8_word_cnt", 32'(word_cnt), 32'd2);
    check("wrflush8_nib", 32'(nib_cnt), 32'd0);
    nib(4'hE); nib(4'hF);
    sb.push_back(map(32'hEF10_0000));
    wr = 1'b1; d = 4'h1; flush = 1'b1; step(); wr = 1'b0; flush = 1'b0;
    check("wrflush3_word_cnt", 32'(word_cnt), 32'd3);
    drain(3);
    check("flush_empty", 32'(empty), 32'd1);

    // Asynchronous reset mid-word
    for (int i = 0; i < 3; i++) begin
      sb.push_back(map(32'h5500_0000 + 32'(i)));
      send_word(32'h5500_0000 + 32'(i), 1'b0, 1'b0);
    end
    for (int i = 0; i < 5; i++) nib(4'(i + 9));
    check("pre_rst_word_cnt", 32'(word_cnt), 32'd3);
    check("pre_rst_nib", 32'(nib_cnt), 32'd5);
    rst = 1'b0;
    #1;
    check("arst_empty", 32'(empty), 32'd1);
    check("arst_word_cnt", 32'(word_cnt), 32'd0);
    check("arst_nib", 32'(nib_cnt), 32'd0);
    check("arst_overrun", 32'(overrun), 32'd0);
    sb.delete();
    step();
    rst = 1'b1;
    step();
    sb.push_back(map(32'h8765_4321));
    send_word(32'h8765_4321, 1'b0, 1'b0);
    check("post_rst_word_cnt", 32'(word_cnt), 32'd1);
    drain(1);
    check("post_rst_empty", 32'(empty), 32'd1);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
